// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - column query/instruction feeder for the mac_col chain
//
// Reads key_beats key rows and then num_q query rows from a synchronous
// single-port SRAM. It drives them into column 0 as a load burst (o_inst=01),
// then one bubble, then an execute stream (o_inst=10). After the last query
// issue it waits drain_cycles cycles and pulses done.
//
// Ports
//   clk, reset      clock (rising edge), synchronous active-low reset
//   start           run request, sampled only while idle
//   num_q           query rows for the run, latched with start
//   key_base        first key row address, latched with start
//   q_base          first query row address, latched with start
//   stall           downstream almost-full; holds back execute reads only
//   mem_cen         SRAM read enable, active-low
//   mem_addr        SRAM address
//   mem_rdata       SRAM read data, one cycle after the sampled read
//   q_out           row presented to column 0
//   o_inst          [1] execute, [0] load, 00 = bubble
//   busy            run in progress
//   done            one-cycle end-of-run pulse
module mac_feeder #(
  parameter int bw           = 8,
  parameter int pr           = 8,
  parameter int addr_w       = 4,
  parameter int key_beats    = 10,
  parameter int drain_cycles = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [addr_w-1:0]    num_q,
  input  logic [addr_w-1:0]    key_base,
  input  logic [addr_w-1:0]    q_base,
  input  logic                 stall,
  output logic                 mem_cen,
  output logic [addr_w-1:0]    mem_addr,
  input  logic [pr*bw-1:0]     mem_rdata,
  output logic [pr*bw-1:0]     q_out,
  output logic [1:0]           o_inst,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] KB_LAST = CNT_W'(key_beats - 1);
  localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(drain_cycles - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_LOAD = 2'b01;
  localparam logic [1:0] TAG_EXEC = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [addr_w-1:0] num_q_q, num_q_d;
  logic [addr_w-1:0] key_base_q, key_base_d;
  logic [addr_w-1:0] q_base_q, q_base_d;
  logic              mem_cen_q, mem_cen_d;
  logic [addr_w-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        rd_tag_q, rd_tag_d;
  logic [1:0]        dat_tag_q;
  logic [pr*bw-1:0]  q_out_q;
  logic [1:0]        o_inst_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  num_q_ext;
  assign num_q_ext = {{(CNT_W-addr_w){1'b0}}, num_q_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_q_d    = num_q_q;
    key_base_d = key_base_q;
    q_base_d   = q_base_q;
    mem_cen_d  = 1'b1;
    mem_addr_d = mem_addr_q;
    rd_tag_d   = TAG_NONE;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_q_d    = num_q;
          key_base_d = key_base;
          q_base_d   = q_base;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // stall is deliberately ignored: columns latch keys on a fixed beat count
        mem_cen_d  = 1'b0;
        mem_addr_d = key_base_q + cnt_q[addr_w-1:0];
        rd_tag_d   = TAG_LOAD;
        if (cnt_q == KB_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = (num_q_q == '0) ? S_DRAIN : S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          mem_cen_d  = 1'b0;
          mem_addr_d = q_base_q + cnt_q[addr_w-1:0];
          rd_tag_d   = TAG_EXEC;
          if (cnt_q + ONE == num_q_ext) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DR_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_q_q    <= '0;
      key_base_q <= '0;
      q_base_q   <= '0;
      mem_cen_q  <= 1'b1;
      mem_addr_q <= '0;
      rd_tag_q   <= TAG_NONE;
      dat_tag_q  <= TAG_NONE;
      q_out_q    <= '0;
      o_inst_q   <= TAG_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q_q    <= num_q_d;
      key_base_q <= key_base_d;
      q_base_q   <= q_base_d;
      mem_cen_q  <= mem_cen_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      // Tag travels with the read: rd_tag with the request, dat_tag while the
      // SRAM data is valid, o_inst alongside the captured row.
      rd_tag_q   <= rd_tag_d;
      dat_tag_q  <= rd_tag_q;
      o_inst_q   <= dat_tag_q;
      // Bubbles keep the previous row so the bus does not toggle needlessly.
      if (dat_tag_q != TAG_NONE) begin
        q_out_q <= mem_rdata;
      end
    end
  end

  assign mem_cen  = mem_cen_q;
  assign mem_addr = mem_addr_q;
  assign q_out    = q_out_q;
  assign o_inst   = o_inst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder
module tb_mac_feeder;

  localparam int BW = 8;
  localparam int PR = 8;
  localparam int AW = 4;
  localparam int KB = 10;
  localparam int DR = 10;
  localparam int DW = PR * BW;
  localparam int NR = 1 << AW;
  localparam int HZ = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_q;
  logic [AW-1:0] key_base;
  logic [AW-1:0] q_base;
  logic          stall;
  logic          mem_cen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] q_out;
  logic [1:0]    o_inst;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mac_feeder #(
    .bw(BW), .pr(PR), .addr_w(AW), .key_beats(KB), .drain_cycles(DR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q),
    .key_base(key_base), .q_base(q_base), .stall(stall),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .q_out(q_out), .o_inst(o_inst), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [NR];
  always @(posedge clk) begin
    if (!mem_cen) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle view of a run, index = clock edges after start was sampled.
  logic [1:0]    e_inst [HZ];
  logic [DW-1:0] e_row  [HZ];
  logic [DW-1:0] e_q    [HZ];
  bit            e_cen  [HZ];
  bit            e_busy [HZ];
  bit            e_done [HZ];
  bit            stall_seq [HZ];
  logic [DW-1:0] model_q = '0;

  task automatic fill_mem(input logic [DW-1:0] salt);
    for (int i = 0; i < NR; i++) begin
      logic [7:0] b;
      b = 8'(i);
      mem[i] = {PR{b}} ^ salt;
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " o_inst"}, 64'(o_inst), 64'd0);
    check({tag, " q_out"}, 64'(q_out), 64'd0);
    check({tag, " mem_cen"}, 64'(mem_cen), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  // stall_pct < 0 selects the directed pattern: stall through load/gap and
  // for the two cycles after the second execute issue.
  task automatic do_run(input int kb, input int qb, input int nq, input int stall_pct,
                        input int abort_at, input bit extra_start);
    int issued, last_t, t, done_t;
    logic [DW-1:0] run_q;
    for (int i = 0; i < HZ; i++) begin
      if (stall_pct < 0) stall_seq[i] = (i <= KB) || (i == KB + 3) || (i == KB + 4);
      else stall_seq[i] = (i < 120) && (int'($urandom_range(99)) < stall_pct);
      e_inst[i] = 2'b00;
      e_row[i]  = '0;
      e_cen[i]  = 1'b1;
    end
    for (int k = 0; k < KB; k++) begin
      e_cen[k+1]  = 1'b0;
      e_inst[k+3] = 2'b01;
      e_row[k+3]  = mem[(kb + k) % NR];
    end
    issued = 0;
    last_t = KB;
    t = KB + 1;
    while (issued < nq) begin
      if (!stall_seq[t]) begin
        e_cen[t+1]  = 1'b0;
        e_inst[t+3] = 2'b10;
        e_row[t+3]  = mem[(qb + issued) % NR];
        issued++;
        last_t = t;
      end
      t++;
    end
    done_t = last_t + DR + 1;
    run_q = model_q;
    for (int i = 0; i < HZ; i++) begin
      if (e_inst[i] != 2'b00) run_q = e_row[i];
      e_q[i]    = run_q;
      e_busy[i] = (i <= done_t);
      e_done[i] = (i == done_t);
    end

    @(negedge clk);
    start    = 1'b1;
    key_base = AW'(kb);
    q_base   = AW'(qb);
    num_q    = AW'(nq);
    stall    = 1'(stall_seq[0]);
    @(posedge clk);
    for (int c = 0; c <= done_t + 1; c++) begin
      @(negedge clk);
      check($sformatf("o_inst@%0d", c), 64'(o_inst), 64'(e_inst[c]));
      check($sformatf("q_out@%0d", c), q_out, e_q[c]);
      check($sformatf("mem_cen@%0d", c), 64'(mem_cen), 64'(e_cen[c]));
      check($sformatf("busy@%0d", c), 64'(busy), 64'(e_busy[c]));
      check($sformatf("done@%0d", c), 64'(done), 64'(e_done[c]));
      if (c == abort_at) begin
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_idle_reset("abort");
        model_q = '0;
        reset = 1'b1;
        for (int w = 0; w < 15; w++) begin
          @(negedge clk);
          check($sformatf("abort_done@%0d", w), 64'(done), 64'd0);
          check($sformatf("abort_inst@%0d", w), 64'(o_inst), 64'd0);
          check($sformatf("abort_busy@%0d", w), 64'(busy), 64'd0);
        end
        return;
      end
      start    = extra_start && (c == 5 || c == done_t);
      key_base = AW'($urandom);
      q_base   = AW'($urandom);
      num_q    = AW'($urandom);
      stall    = stall_seq[c];
    end
    model_q = e_q[done_t + 1];
    start = 1'b0;
    stall = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check($sformatf("post_busy@%0d", w), 64'(busy), 64'd0);
      check($sformatf("post_inst@%0d", w), 64'(o_inst), 64'd0);
      check($sformatf("post_q@%0d", w), q_out, model_q);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; stall = 1'b0;
    num_q = '0; key_base = '0; q_base = '0;
    fill_mem('0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_reset($sformatf("reset%0d", i));
    end
    reset = 1'b1;
    start = 1'b0;

    do_run(0, 10, 4, 0, -1, 1'b0);
    do_run(0, 10, 4, -1, -1, 1'b0);
    do_run(12, 0, 3, 30, -1, 1'b0);
    do_run(0, 10, 4, 0, 15, 1'b0);
    do_run(0, 10, 4, 0, -1, 1'b0);
    do_run(5, 3, 0, 20, -1, 1'b1);

    for (int r = 0; r < 20; r++) begin
      fill_mem({$urandom, $urandom});
      do_run(int'($urandom_range(NR-1)), int'($urandom_range(NR-1)),
             int'($urandom_range(NR-1)), int'($urandom_range(60)), -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
